// File: rtl/inst_cache.sv
// ---------------------------------------------------------------------------
// inst_cache -- direct-mapped instruction cache, 4-word (16-byte) lines.
//
// A fetch address is registered in IDLE and looked up on the following cycle.
// A hit delivers the word that cycle. A miss stalls the fetch stage and
// refills the whole line from memory, one word per mem_valid beat. The line
// is then presented for one DONE cycle.
//
// Parameters
//   INDEX_W    index width; the cache holds 2^INDEX_W lines of 4 words
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   cache_en   fetch lookup enable from the PC stage
//   inst_addr  fetch address (next PC), bits [1:0] ignored
//   clear      pipeline flush; suppresses delivery of a pending miss
//   inst_o     fetched instruction word
//   cache_hit  inst_o is valid for the previously sampled address
//   stall_req  freeze request to the fetch stage
//   mem_req    refill request, held high for the whole refill
//   mem_addr   refill address (line aligned, or word aligned when uncached)
//   mem_valid  one returned word per asserted cycle
//   mem_rdata  returned word
//
// Build option
//   UNCACHED_KSEG1_EN  when defined, 0xA000_0000-0xBFFF_FFFF bypass the cache:
//                      single-word fetch, no array update.
// ---------------------------------------------------------------------------
module inst_cache #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_en,
  input  logic [31:0] inst_addr,
  input  logic        clear,
  output logic [31:0] inst_o,
  output logic        cache_hit,
  output logic        stall_req,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 28 - INDEX_W;

  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

  state_t state, state_next;

  // Request bookkeeping
  logic [31:2]        req_addr;   // address of the lookup / refill in flight
  logic               pending;    // a lookup result is due this cycle (IDLE)
  logic [1:0]         beat_cnt;   // next word offset to be written
  logic               flushed;    // clear seen during the refill
  logic [31:0]        done_word;  // missed word, presented in DONE

  // Line storage
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES*4];

  // Address fields of the request in flight
  logic [1:0]         req_off;
  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;

  assign req_off = req_addr[3:2];
  assign req_idx = req_addr[INDEX_W+3:4];
  assign req_tag = req_addr[31:INDEX_W+4];

  // Byte-select bits of the fetch address are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^inst_addr[1:0];

  logic uncached;
`ifdef UNCACHED_KSEG1_EN
  assign uncached = (req_addr[31:29] == 3'b101);
`else
  assign uncached = 1'b0;
`endif

  logic lookup, tag_match, miss, start_refill, beat, last_beat, accept;

  assign lookup       = (state == IDLE) && pending;
  assign tag_match    = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !uncached;
  assign miss         = lookup && !tag_match;
  // A flush in the result cycle of a miss cancels the refill before it starts.
  assign start_refill = miss && !clear;
  assign beat         = (state == REFILL) && mem_valid;
  assign last_beat    = beat && (uncached || (beat_cnt == 2'd3));
  // The address register is free except while a miss is being serviced.
  assign accept       = ((state == IDLE) && !start_refill) || (state == DONE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves a signal unassigned would infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (start_refill) state_next = REFILL;
      REFILL:  if (last_beat)    state_next = DONE;
      DONE:                      state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    inst_o    = '0;
    cache_hit = 1'b0;
    stall_req = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    unique case (state)
      IDLE: begin
        if (lookup) begin
          if (tag_match) begin
            cache_hit = 1'b1;
            inst_o    = data_mem[{req_idx, req_off}];
          end else if (!clear) begin
            stall_req = 1'b1;
          end
        end
      end
      REFILL: begin
        stall_req = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = uncached ? {req_addr, 2'b00} : {req_addr[31:4], 4'b0000};
      end
      DONE: begin
        if (!flushed && !clear) begin
          cache_hit = 1'b1;
          inst_o    = done_word;
        end
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------ control state
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 1'b0;
      beat_cnt <= 2'd0;
      flushed  <= 1'b0;
      valid    <= '0;
    end else begin
      if (accept)       pending <= cache_en;
      else              pending <= 1'b0;
      if (start_refill) begin
        beat_cnt <= 2'd0;
        flushed  <= 1'b0;
      end
      if (state == REFILL && clear) flushed <= 1'b1;
      if (beat)                     beat_cnt <= beat_cnt + 2'd1;
      // The line only becomes visible once all four words are in place.
      if (last_beat && !uncached)   valid[req_idx] <= 1'b1;
    end
  end

  // ---------------------------------------------------------- datapath
  // NOTE: tag and data arrays carry no reset; the valid bits alone decide
  // whether their contents mean anything, which keeps them RAM-mappable.
  always_ff @(posedge clk) begin
    if (accept && cache_en)        req_addr <= inst_addr[31:2];
    if (beat && !uncached)         data_mem[{req_idx, beat_cnt}] <= mem_rdata;
    if (last_beat && !uncached)    tag_mem[req_idx] <= req_tag;
    if (beat && (uncached || beat_cnt == req_off)) done_word <= mem_rdata;
  end

endmodule

// File: tb/tb_inst_cache.sv
// ---------------------------------------------------------------------------
// tb_inst_cache -- self-checking bench for inst_cache (INDEX_W = 6).
// The reference model tracks valid/tag/data per line with plain arrays and
// decides hit or miss from address arithmetic; memory contents come from a
// fixed address hash unless a scenario overrides the beat words.
// ---------------------------------------------------------------------------
module tb_inst_cache;

  localparam int INDEX_W = 6;
  localparam int LINES   = 1 << INDEX_W;

  logic        clk = 1'b0;
  logic        rst, cache_en, clear, mem_valid;
  logic [31:0] inst_addr, mem_rdata;
  logic [31:0] inst_o, mem_addr;
  logic        cache_hit, stall_req, mem_req;

  int total = 0;
  int bad   = 0;

  // Reference model
  bit          mdl_valid [LINES];
  logic [31:0] mdl_tag   [LINES];
  logic [31:0] mdl_data  [LINES*4];
  bit          use_fixed = 0;
  logic [31:0] fixed_words [4];

  inst_cache #(.INDEX_W(INDEX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cache_en  (cache_en),
    .inst_addr (inst_addr),
    .clear     (clear),
    .inst_o    (inst_o),
    .cache_hit (cache_hit),
    .stall_req (stall_req),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic bit is_uncached(input logic [31:0] a);
`ifdef UNCACHED_KSEG1_EN
    return (a >= 32'hA000_0000) && (a <= 32'hBFFF_FFFF);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mdl_valid[i] = 0;
  endtask

  // One complete fetch: lookup, and on a miss the whole refill plus DONE.
  // clear_beat: beat number (0-based) during which clear is raised, -1 none.
  // clear_result: raise clear in the result cycle of a miss.
  task automatic do_fetch(input logic [31:0] a, input int clear_beat, input bit clear_result);
    int          idx, off, nbeats, got, guard;
    logic [31:0] tg, base, exp_word;
    logic [31:0] w [4];
    bit          unc, hit, give, exp_hit;
    idx  = int'((a >> 4) % LINES);
    off  = int'((a >> 2) % 4);
    tg   = a >> (INDEX_W + 4);
    unc  = is_uncached(a);
    base = unc ? (a & 32'hFFFF_FFFC) : (a & 32'hFFFF_FFF0);
    for (int i = 0; i < 4; i++)
      w[i] = use_fixed ? fixed_words[i] : mem_word(base + 32'(4 * i));
    hit = !unc && mdl_valid[idx] && (mdl_tag[idx] == tg);

    step();
    cache_en = 1'b1; inst_addr = a; clear = 1'b0; mem_valid = 1'b0;
    step();
    cache_en = 1'b0; clear = clear_result && !hit;
    @(negedge clk);
    total++;
    if (hit) begin
      if (cache_hit !== 1'b1 || inst_o !== mdl_data[idx*4+off] || stall_req !== 1'b0 || mem_req !== 1'b0) begin
        bad++;
        $display("FAIL hit_result addr=%h: hit=%b inst=%h stall=%b req=%b, want hit=1 inst=%h stall=0 req=0",
                 a, cache_hit, inst_o, stall_req, mem_req, mdl_data[idx*4+off]);
      end
      clear = 1'b0;
      return;
    end
    if (cache_hit !== 1'b0 || stall_req !== !clear_result) begin
      bad++;
      $display("FAIL miss_result addr=%h: hit=%b stall=%b, want hit=0 stall=%b",
               a, cache_hit, stall_req, !clear_result);
    end
    if (clear_result) begin
      step();
      clear = 1'b0;
      @(negedge clk);
      total++;
      if (mem_req !== 1'b0 || stall_req !== 1'b0 || cache_hit !== 1'b0) begin
        bad++;
        $display("FAIL cleared_miss addr=%h: req=%b stall=%b hit=%b, want all 0",
                 a, mem_req, stall_req, cache_hit);
      end
      return;
    end

    nbeats = unc ? 1 : 4;
    got    = 0;
    guard  = 0;
    step();
    while (got < nbeats && guard < 200) begin
      give      = ($urandom % 3) != 0;
      mem_valid = give;
      mem_rdata = give ? w[got] : $urandom;
      clear     = give && (got == clear_beat);
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || mem_addr !== base || stall_req !== 1'b1 || cache_hit !== 1'b0) begin
        bad++;
        $display("FAIL refill addr=%h beat=%0d: req=%b maddr=%h stall=%b hit=%b, want req=1 maddr=%h stall=1 hit=0",
                 a, got, mem_req, mem_addr, stall_req, cache_hit, base);
      end
      if (give) got++;
      guard++;
      step();
    end
    if (guard >= 200) begin
      total++;
      bad++;
      $display("FAIL refill_timeout addr=%h: beats=%0d, want %0d", a, got, nbeats);
    end
    // A stray beat in DONE must be ignored.
    mem_valid = 1'($urandom % 2);
    mem_rdata = $urandom;
    clear     = 1'b0;
    exp_hit   = (clear_beat < 0) || (clear_beat >= nbeats);
    exp_word  = unc ? w[0] : w[off];
    @(negedge clk);
    total++;
    if (cache_hit !== exp_hit || (exp_hit && inst_o !== exp_word) || stall_req !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL done addr=%h: hit=%b inst=%h stall=%b req=%b, want hit=%b inst=%h stall=0 req=0",
               a, cache_hit, inst_o, stall_req, mem_req, exp_hit, exp_word);
    end
    mem_valid = 1'b0;
    if (!unc) begin
      mdl_valid[idx] = 1;
      mdl_tag[idx]   = tg;
      for (int i = 0; i < 4; i++) mdl_data[idx*4+i] = w[i];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cache_en = 1'b1; inst_addr = 32'h8000_0000; clear = 1'b0;
    mem_valid = 1'b0; mem_rdata = '0;
    repeat (3) step();
    rst = 1'b0; cache_en = 1'b0;
    model_clear();
    @(negedge clk);
    total++;
    if (inst_o !== 32'h0 || cache_hit !== 1'b0 || stall_req !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: inst=%h hit=%b stall=%b req=%b maddr=%h, want all 0",
               inst_o, cache_hit, stall_req, mem_req, mem_addr);
    end
  endtask

  task automatic test_basic_refill();
    use_fixed = 1;
    fixed_words[0] = 32'h11; fixed_words[1] = 32'h22;
    fixed_words[2] = 32'h33; fixed_words[3] = 32'h44;
    do_fetch(32'h8000_0000, -1, 0);
    use_fixed = 0;
    do_fetch(32'h8000_0008, -1, 0);
  endtask

  task automatic test_conflict();
    do_fetch(32'h8000_0400, -1, 0);
    do_fetch(32'h8000_0000, -1, 0);
    do_fetch(32'h8000_040C, -1, 0);
  endtask

  task automatic test_clear();
    do_fetch(32'h8000_0044, 1, 0);
    do_fetch(32'h8000_0044, -1, 0);
    do_fetch(32'h8000_0058, 3, 0);
    do_fetch(32'h8000_0050, -1, 1);
    do_fetch(32'h8000_0054, -1, 0);
  endtask

  task automatic test_reset_abort();
    logic [31:0] a;
    a = 32'h8000_0120;
    step();
    cache_en = 1'b1; inst_addr = a;
    step();
    cache_en = 1'b0;
    step();
    mem_valid = 1'b1; mem_rdata = 32'hAAAA_0001;
    step();
    mem_rdata = 32'hAAAA_0002;
    step();
    mem_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; mem_valid = 1'b1; mem_rdata = 32'hAAAA_0003;
    model_clear();
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || stall_req !== 1'b0 || cache_hit !== 1'b0 || inst_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_abort: req=%b maddr=%h stall=%b hit=%b inst=%h, want all 0",
               mem_req, mem_addr, stall_req, cache_hit, inst_o);
    end
    step();
    mem_valid = 1'b0;
    do_fetch(a, -1, 0);
  endtask

  task automatic test_uncached();
    use_fixed = 1;
    fixed_words[0] = 32'hDEAD_BEEF; fixed_words[1] = 32'h0BAD_0001;
    fixed_words[2] = 32'h0BAD_0002; fixed_words[3] = 32'h0BAD_0003;
    do_fetch(32'hBFC0_0004, -1, 0);
    do_fetch(32'hBFC0_0004, -1, 0);
    use_fixed = 0;
  endtask

  task automatic test_disabled();
    step();
    cache_en = 1'b0; inst_addr = 32'h8000_0000;
    step();
    @(negedge clk);
    total++;
    if (cache_hit !== 1'b0 || stall_req !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL disabled: hit=%b stall=%b req=%b, want 0 0 0", cache_hit, stall_req, mem_req);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int cb;
    bit cr;
    for (int n = 0; n < 60; n++) begin
      a  = 32'h8000_0000 | (($urandom % 4) << 10) | (($urandom % 8) << 4) | (($urandom % 4) << 2);
      cb = (($urandom % 5) == 0) ? int'($urandom % 4) : -1;
      cr = ($urandom % 8) == 0;
      do_fetch(a, cb, cr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    logic [31:0] a, exp_word;
    int idx, off;
    for (int i = 0; i < LINES && q.size() < 10; i++)
      if (mdl_valid[i]) q.push_back((mdl_tag[i] << (INDEX_W + 4)) | (i << 4) | (($urandom % 4) << 2));
    if (q.size() == 0) return;
    step();
    cache_en = 1'b1; inst_addr = q[0];
    for (int k = 1; k <= q.size(); k++) begin
      step();
      if (k < q.size()) inst_addr = q[k];
      else              cache_en  = 1'b0;
      a        = q[k-1];
      idx      = int'((a >> 4) % LINES);
      off      = int'((a >> 2) % 4);
      exp_word = mdl_data[idx*4+off];
      @(negedge clk);
      total++;
      if (cache_hit !== 1'b1 || inst_o !== exp_word || stall_req !== 1'b0) begin
        bad++;
        $display("FAIL back_to_back addr=%h: hit=%b inst=%h stall=%b, want hit=1 inst=%h stall=0",
                 a, cache_hit, inst_o, stall_req, exp_word);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_refill();
    test_conflict();
    test_clear();
    test_reset_abort();
    test_uncached();
    test_disabled();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
